// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: three-flop synchroniser, start-bit validation,
// mid-bit sampling, one-cycle rx_flag / frame_err strobes.
module uart_rx #(
  parameter int unsigned BAUD_END = 5208,
  parameter int unsigned BAUD_MID = BAUD_END / 2 - 1,
  parameter int unsigned BIT_END  = 10
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_r1, rx_r2, rx_r3;
  logic [12:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic        start_edge, sample, baud_wrap, counters_clr;
  logic        shift_en, frame_ok, frame_bad;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rx_r1 <= 1'b1;
      rx_r2 <= 1'b1;
      rx_r3 <= 1'b1;
    end else begin
      rx_r1 <= rs232_rx;
      rx_r2 <= rx_r1;
      rx_r3 <= rx_r2;
    end
  end

  assign start_edge = rx_r3 & ~rx_r2;
  assign sample     = (baud_cnt == 13'(BAUD_MID));
  assign baud_wrap  = (baud_cnt == 13'(BAUD_END - 1));
  assign bit_idx    = 3'(bit_cnt - 4'd1);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (sample) state_nxt = rx_r2 ? IDLE : DATA;
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'(BIT_END - 2)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          frame_ok  = rx_r2;
          frame_bad = ~rx_r2;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clearing on the way into IDLE as well means the cycle after an abort or
  // a mid-stop-bit exit already sees zeroed counters.
  assign counters_clr = (state == IDLE) || (state_nxt == IDLE);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (counters_clr) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (baud_wrap) begin
      baud_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + 13'd1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      shift_reg <= '0;
      rx_data   <= '0;
      rx_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (shift_en) shift_reg[bit_idx] <= rx_r2;
      if (frame_ok) rx_data <= shift_reg;
      rx_flag   <= frame_ok;
      frame_err <= frame_bad;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written glitch,
// stuck-low and mid-frame reset sequences; strobes checked against a scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned B   = 64;
  localparam int unsigned MID = B / 2 - 1;
  localparam int unsigned NV  = 7;

  logic       sclk = 1'b0;
  logic       s_rst_n;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_flag, frame_err, rx_busy;

  always #5 sclk = ~sclk;

  uart_rx #(.BAUD_END(B), .BAUD_MID(MID), .BIT_END(10)) dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .rs232_rx (rs232_rx),
    .rx_data  (rx_data),
    .rx_flag  (rx_flag),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  typedef struct {
    logic        err;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    logic        glitch;
    int unsigned gap;
    logic        exp_err;
    logic [7:0]  exp_data;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[NV];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int unsigned last_flag_cyc = 0;
  int unsigned n_strobe = 0;
  int unsigned n_push = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic v);
    rs232_rx = v;
    repeat (B) @(negedge sclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic push,
                            input logic exp_err, input logic [7:0] exp_data);
    if (push) begin
      sb.push_back('{err: exp_err, data: exp_data});
      n_push++;
    end
    t_start = cyc;
    send_bit(1'b0);
    for (int unsigned k = 0; k < 8; k++) send_bit(b[k]);
    send_bit(stop_v);
    rs232_rx = 1'b1;
  endtask

  task automatic monitor();
    logic pf, pe;
    exp_t e;
    pf = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge sclk);
      if (s_rst_n && (rx_flag || frame_err)) begin
        n_strobe++;
        chk("strobe_exclusive", 32'(rx_flag & frame_err), 0);
        chk("strobe_width", 32'(pf | pe), 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe: flag=%0b err=%0b data=0x%02h, required no strobe",
                   rx_flag, frame_err, rx_data);
        end else begin
          e = sb.pop_front();
          chk("strobe_kind(frame_err)", 32'(frame_err), 32'(e.err));
          chk("rx_data", 32'(rx_data), 32'(e.data));
        end
        if (rx_flag) last_flag_cyc = cyc;
      end
      pf = rx_flag;
      pe = frame_err;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b0, 20, 1'b0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 20, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 20, 1'b1, 8'hA5};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 20, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 0,  1'b0, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 0,  1'b0, 8'h81};
    vecs[6] = '{8'h6B, 1'b1, 1'b0, 3,  1'b0, 8'h6B};

    rs232_rx = 1'b1;
    s_rst_n  = 1'b0;
    repeat (3) @(negedge sclk);
    chk("reset rx_data", 32'(rx_data), 0);
    chk("reset rx_flag", 32'(rx_flag), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset rx_busy", 32'(rx_busy), 0);
    s_rst_n = 1'b1;
    fork
      monitor();
    join_none

    repeat (2000) @(negedge sclk);
    chk("idle rx_data", 32'(rx_data), 0);
    chk("idle rx_busy", 32'(rx_busy), 0);
    chk("idle strobes", n_strobe, 0);

    for (int unsigned i = 0; i < NV; i++) begin
      rs232_rx = 1'b1;
      repeat (vecs[i].gap) @(negedge sclk);
      if (vecs[i].glitch) begin
        rs232_rx = 1'b0;
        repeat (10) @(negedge sclk);
        rs232_rx = 1'b1;
        repeat (10) @(negedge sclk);
        chk("glitch rx_busy high", 32'(rx_busy), 1);
        repeat (20) @(negedge sclk);
        chk("glitch rx_busy low", 32'(rx_busy), 0);
        repeat (20) @(negedge sclk);
      end
      send_frame(vecs[i].data, vecs[i].stop_ok, 1'b1, vecs[i].exp_err, vecs[i].exp_data);
      chk("frame rx_busy after stop", 32'(rx_busy), 0);
      if (i == 0) chk("start->flag latency", last_flag_cyc - t_start, 9 * B + MID + 4);
    end

    // Framing error with the line left low afterwards: one frame_err only.
    repeat (5) @(negedge sclk);
    send_frame(8'hC5, 1'b0, 1'b1, 1'b1, 8'h6B);
    rs232_rx = 1'b0;
    repeat (3 * B) @(negedge sclk);
    chk("stuck-low rx_busy", 32'(rx_busy), 0);
    rs232_rx = 1'b1;
    repeat (2 * B) @(negedge sclk);
    chk("stuck-low rx_busy after release", 32'(rx_busy), 0);

    // Reset mid-frame: the aborted frame must produce no strobe.
    fork
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
      begin
        repeat (4 * B + B / 2) @(negedge sclk);
        s_rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        chk("mid-reset rx_data", 32'(rx_data), 0);
        chk("mid-reset rx_flag", 32'(rx_flag), 0);
        chk("mid-reset frame_err", 32'(frame_err), 0);
        chk("mid-reset rx_busy", 32'(rx_busy), 0);
      end
    join
    repeat (10) @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (20) @(negedge sclk);
    chk("post-reset rx_busy", 32'(rx_busy), 0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E);

    repeat (3 * B) @(negedge sclk);
    chk("scoreboard drained", sb.size(), 0);
    chk("strobe count", n_strobe, n_push);
    chk("final rx_data", 32'(rx_data), 32'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
